// File: rtl/request_queue_pkg.sv
// req_queue_pkg: shared widths, types and limits for the request queue
package req_queue_pkg;
    localparam int NUM_REQ  = 8;
    localparam int IDX_W    = 3;
    localparam int CNT_W    = 3;
    localparam int TOT_W    = CNT_W + 3;
    localparam int STARVE_T = 15;
    localparam int WAIT_W   = 4;
    typedef logic [IDX_W-1:0]  req_idx_t;
    typedef logic [CNT_W-1:0]  pend_cnt_t;
    typedef logic [TOT_W-1:0]  total_t;
    typedef logic [WAIT_W-1:0] wait_cnt_t;
    localparam pend_cnt_t CNT_MAX  = '1;
    localparam wait_cnt_t WAIT_MAX = wait_cnt_t'(STARVE_T);
endpackage

// File: rtl/request_queue_if.sv
// request_queue_if: requestor/arbiter-facing bus of the request queue (starve_o only with REQ_QUEUE_STARVE_EN)
interface request_queue_if import req_queue_pkg::*; ();
    logic [NUM_REQ-1:0] req_pulse_i;
    logic               flush_i;
    req_idx_t           grant_idx_i;
    logic               grant_vld_i;
    logic [NUM_REQ-1:0] reqs_o;
    total_t             total_o;
    logic               overflow_o;
    logic               grant_err_o;
`ifdef REQ_QUEUE_STARVE_EN
    logic [NUM_REQ-1:0] starve_o;
    modport master (output req_pulse_i, flush_i, grant_idx_i, grant_vld_i,
                    input reqs_o, total_o, overflow_o, grant_err_o, starve_o);
    modport slave  (input req_pulse_i, flush_i, grant_idx_i, grant_vld_i,
                    output reqs_o, total_o, overflow_o, grant_err_o, starve_o);
`else
    modport master (output req_pulse_i, flush_i, grant_idx_i, grant_vld_i,
                    input reqs_o, total_o, overflow_o, grant_err_o);
    modport slave  (input req_pulse_i, flush_i, grant_idx_i, grant_vld_i,
                    output reqs_o, total_o, overflow_o, grant_err_o);
`endif
endinterface

// File: rtl/request_queue_counter.sv
// req_counter: saturating pending-request counter for one requestor (wait counter with REQ_QUEUE_STARVE_EN)
module req_counter import req_queue_pkg::*; (
    input  logic      clock,
    input  logic      reset,
    input  logic      inc,
    input  logic      dec,
    input  logic      flush,
    output pend_cnt_t cnt,
    output logic      nonzero,
`ifdef REQ_QUEUE_STARVE_EN
    output wait_cnt_t wait_cnt,
`endif
    output logic      ovf_pulse
);
    // a simultaneous inc and dec cancel, so a full counter with a grant never overflows
    always_comb begin
        nonzero   = cnt != '0;
        ovf_pulse = inc && !dec && !flush && cnt == CNT_MAX;
    end
    // pending count: flush drops everything including this cycle's pulse
    always_ff @(posedge clock)
        if (reset || flush) cnt <= '0;
        else if (inc && !dec && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        else if (dec && !inc) cnt <= cnt - 1'b1;
`ifdef REQ_QUEUE_STARVE_EN
    // cycles spent pending without a grant, saturating at the starvation threshold
    always_ff @(posedge clock)
        if (reset || flush || !nonzero || dec) wait_cnt <= '0;
        else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
`endif
endmodule

// File: rtl/request_queue.sv
// request_queue: per-requestor pending counters feeding the round-robin arbiter; REQ_QUEUE_STARVE_EN adds starvation flags
module request_queue import req_queue_pkg::*; (
    input logic             clock,
    input logic             reset,
    request_queue_if.slave  bus
);
    logic [NUM_REQ-1:0] grant_dec, dec, nonzero, ovf_pulse;
    pend_cnt_t          cnt [NUM_REQ];
    total_t             total;
    logic               overflow, grant_err;
`ifdef REQ_QUEUE_STARVE_EN
    wait_cnt_t          wait_cnt [NUM_REQ];
`endif
    // one-hot grant decode; a grant only retires a request that actually exists
    always_comb begin
        grant_dec = bus.grant_vld_i ? NUM_REQ'(1) << bus.grant_idx_i : '0;
        dec       = grant_dec & nonzero;
    end
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        req_counter u_cnt (
            .clock     (clock),
            .reset     (reset),
            .inc       (bus.req_pulse_i[i]),
            .dec       (dec[i]),
            .flush     (bus.flush_i),
            .cnt       (cnt[i]),
            .nonzero   (nonzero[i]),
`ifdef REQ_QUEUE_STARVE_EN
            .wait_cnt  (wait_cnt[i]),
`endif
            .ovf_pulse (ovf_pulse[i])
        );
`ifdef REQ_QUEUE_STARVE_EN
        assign bus.starve_o[i] = wait_cnt[i] >= WAIT_MAX;
`endif
    end
    // total is decoded from registers only, keeping the arbiter loop free of combinational paths
    always_comb begin
        total = '0;
        for (int i = 0; i < NUM_REQ; i++) total = total + TOT_W'(cnt[i]);
    end
    // sticky error flags, cleared only by reset
    always_ff @(posedge clock)
        if (reset) begin
            overflow  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            overflow  <= overflow | (|ovf_pulse);
            grant_err <= grant_err | (bus.grant_vld_i && !nonzero[bus.grant_idx_i]);
        end
    assign bus.reqs_o      = nonzero;
    assign bus.total_o     = total;
    assign bus.overflow_o  = overflow;
    assign bus.grant_err_o = grant_err;
endmodule

// File: tb/tb_request_queue.sv
// tb_request_queue: directed stimulus with a queue-level reference model checked every cycle
module tb_request_queue;
    import req_queue_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    request_queue_if bus();
    request_queue dut (.clock(clock), .reset(reset), .bus(bus));
    int total_n = 0;
    int bad_n = 0;
    int m_cnt [NUM_REQ];
    int m_wait [NUM_REQ];
    bit m_ovf, m_gerr, live;
    localparam int MAXC = (1 << CNT_W) - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [7:0] p, input bit f = 0, input int gi = 0, input bit gv = 0);
        bus.req_pulse_i = p;
        bus.flush_i     = f;
        bus.grant_idx_i = 3'(gi);
        bus.grant_vld_i = gv;
        @(posedge clock);
        #1;
    endtask

    // reference model: requests as integer counts per requestor
    always @(posedge clock) begin
        int old [NUM_REQ];
        bit g;
        old = m_cnt;
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                m_cnt[i] = 0;
                m_wait[i] = 0;
            end
            m_ovf = 0;
            m_gerr = 0;
            live = 1;
        end else begin
            if (bus.grant_vld_i && old[bus.grant_idx_i] == 0) m_gerr = 1;
            for (int i = 0; i < NUM_REQ; i++) begin
                g = bus.grant_vld_i && bus.grant_idx_i == i && old[i] > 0;
                if (bus.flush_i) begin
                    m_cnt[i] = 0;
                    m_wait[i] = 0;
                end else begin
                    if (bus.req_pulse_i[i] && !g) begin
                        if (old[i] == MAXC) m_ovf = 1;
                        else m_cnt[i] = old[i] + 1;
                    end else if (g && !bus.req_pulse_i[i]) m_cnt[i] = old[i] - 1;
                    m_wait[i] = (old[i] == 0 || g) ? 0 : (m_wait[i] < STARVE_T ? m_wait[i] + 1 : STARVE_T);
                end
            end
        end
    end

    // every-cycle comparison of DUT outputs against the model
    always @(negedge clock) begin
        logic [7:0] er;
        int et;
        if (live) begin
            er = '0;
            et = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                er[i] = m_cnt[i] != 0;
                et += m_cnt[i];
            end
            check("mdl_reqs", bus.reqs_o, er);
            check("mdl_total", bus.total_o, et);
            check("mdl_ovf", bus.overflow_o, m_ovf);
            check("mdl_gerr", bus.grant_err_o, m_gerr);
`ifdef REQ_QUEUE_STARVE_EN
            er = '0;
            for (int i = 0; i < NUM_REQ; i++) er[i] = m_wait[i] >= STARVE_T;
            check("mdl_starve", bus.starve_o, er);
`endif
        end
    end

    initial begin
        int idx, last;
        reset = 1'b1;
        cyc(8'hFF);
        cyc(8'hFF);
        check("rst_reqs", bus.reqs_o, 0);
        check("rst_total", bus.total_o, 0);
        check("rst_ovf", bus.overflow_o, 0);
        check("rst_gerr", bus.grant_err_o, 0);
        reset = 1'b0;
        cyc(8'h00);
        check("rel_reqs", bus.reqs_o, 0);
        cyc(8'h05);
        check("t2_reqs", bus.reqs_o, 8'h05);
        check("t2_total", bus.total_o, 2);
        cyc(8'h00, 0, 0, 1);
        check("t2_grant_reqs", bus.reqs_o, 8'h04);
        check("t2_grant_total", bus.total_o, 1);
        cyc(8'h00, 0, 2, 1);
        check("t2_clear", bus.reqs_o, 0);
        repeat (7) cyc(8'h08);
        check("t3_ovf_7th", bus.overflow_o, 0);
        cyc(8'h08);
        check("t3_ovf_8th", bus.overflow_o, 1);
        check("t3_total", bus.total_o, 7);
        check("t3_reqs", bus.reqs_o, 8'h08);
        repeat (6) cyc(8'h00, 0, 3, 1);
        check("t3_reqs_6g", bus.reqs_o, 8'h08);
        cyc(8'h00, 0, 3, 1);
        check("t3_reqs_7g", bus.reqs_o, 0);
        check("t3_ovf_sticky", bus.overflow_o, 1);
        reset = 1'b1;
        cyc(8'h00);
        reset = 1'b0;
        repeat (7) cyc(8'h04);
        check("t4_total", bus.total_o, 7);
        cyc(8'h04, 0, 2, 1);
        check("t4_total_hold", bus.total_o, 7);
        check("t4_no_ovf", bus.overflow_o, 0);
        repeat (7) cyc(8'h00, 0, 2, 1);
        check("t4_drain", bus.total_o, 0);
        cyc(8'h00, 0, 6, 1);
        check("t5_gerr", bus.grant_err_o, 1);
        check("t5_total", bus.total_o, 0);
        cyc(8'hFF);
        check("t5_load", bus.reqs_o, 8'hFF);
        cyc(8'hFF, 1);
        check("t5_flush_reqs", bus.reqs_o, 0);
        check("t5_flush_total", bus.total_o, 0);
        check("t5_gerr_sticky", bus.grant_err_o, 1);
        cyc(8'hFF);
        cyc(8'hFF);
        check("t6_load", bus.total_o, 16);
        last = 7;
        for (int k = 0; k < 16; k++) begin
            idx = -1;
            for (int j = 1; j <= NUM_REQ; j++)
                if (idx < 0 && bus.reqs_o[(last + j) % NUM_REQ]) idx = (last + j) % NUM_REQ;
            check("t6_rr_idx", idx, k % NUM_REQ);
            cyc(8'h00, 0, idx < 0 ? 0 : idx, idx >= 0);
            if (idx >= 0) last = idx;
        end
        check("t6_total", bus.total_o, 0);
        check("t6_reqs", bus.reqs_o, 0);
`ifdef REQ_QUEUE_STARVE_EN
        cyc(8'h02);
        repeat (14) cyc(8'h00);
        check("t6_starve_14", bus.starve_o, 0);
        cyc(8'h00);
        check("t6_starve_15", bus.starve_o, 8'h02);
`endif
        cyc(8'h00);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
